mem_data_ctrl: RTL and testbench
================================

Name: mem_data_ctrl

Overview:
- Responder side of the load-store buffer's data-memory request interface.
- Accepts one load or store request at a time and serialises it onto the byte-wide RAM port, one byte per cycle, little-endian.
- For loads: assembles the bytes and sign- or zero-extends the result. Then returns a one-cycle done pulse with the data.
- Sits between the load-store buffer and the RAM/IO port. Handles the IO-buffer-full stall and branch-misprediction abort of in-flight loads.

Parameters:
- ADR_W, 32, RAM address width.
- IO_BASE_BIT, 17, address bits [17:16]==2'b11 mark the IO region.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- en  input  1  global ready; low freezes all state
- lsb_en_i  input  1  request strobe, one cycle
- lsb_rwen_i  input  1  0 = read, 1 = write
- lsb_op_i  input  OP_W  op code (head.v encodings `LB/`LH/`LW/`LBU/`LHU/`SB/`SH/`SW)
- lsb_len_i  input  3  byte count: 1, 2 or 4
- lsb_adr_i  input  32  byte address
- lsb_dat_i  input  32  store data (low len bytes used)
- abort_i  input  1  branch misprediction flush
- io_buffer_full_i  input  1  IO write sink full
- lsb_en_o  output  1  done pulse, one cycle
- lsb_dat_o  output  32  load result (extended); 0 for stores
- busy_o  output  1  request in progress
- mem_din_i  input  8  RAM read byte
- mem_dout_o  output  8  RAM write byte
- mem_a_o  output  ADR_W  RAM address
- mem_wr_o  output  1  RAM write enable

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0, assembly register 0.
- States are IDLE, READ and WRITE. busy_o is high in READ and WRITE.
- RAM timing: the byte for the address driven during cycle c is valid on mem_din_i during cycle c+1.
- Accepting a request:
  - In IDLE, a request is accepted at edge E0 when en && lsb_en_i && !abort_i.
  - At E0: latch op, len, adr and data; drive mem_a_o <= adr; counter <= 0.
  - lsb_en_i while busy is ignored; the requester guarantees it does not issue one.
- READ:
  - At edge Ek (k ≥ 1), mem_a_o <= adr+k while k < len.
  - At edge E(k+1), mem_din_i is written into assembly byte k.
  - At E(len+1), the last byte is sampled. At that edge: lsb_dat_o <= extended value, lsb_en_o <= 1, return to IDLE.
  - Done pulse therefore arrives len+1 edges after accept (LW: 5).
  - Extension: `LB sign-extends bit 7; `LH sign-extends bit 15; `LBU/`LHU zero-extend; `LW passes through.
- WRITE:
  - At E0: mem_dout_o <= dat[7:0], mem_wr_o <= 1.
  - At Ek (k < len): mem_a_o <= adr+k, mem_dout_o <= dat[8k+7:8k], mem_wr_o <= 1.
  - At E(len): mem_wr_o <= 0, lsb_en_o <= 1, lsb_dat_o <= 0, return to IDLE.
  - Done pulse arrives len edges after accept.
- IO stall:
  - Applies to a write whose adr[17:16]==2'b11 while io_buffer_full_i is high.
  - Hold mem_wr_o at 0 and do not advance the counter; the current byte is held.
  - Resume on the first edge where io_buffer_full_i is low; the same byte is then written.
- abort_i:
  - In READ, the next edge returns to IDLE. mem_a_o is held, no lsb_en_o, assembly register is cleared.
  - This applies even on the would-be final edge (pulse suppressed).
  - In WRITE, abort_i is ignored; committed stores always complete.
  - In IDLE, a same-cycle request is dropped.
- en low: state, counter and data are frozen; mem_wr_o <= 0; lsb_en_o <= 0. On en high, the interrupted byte is re-driven.
- lsb_en_o is a single-cycle pulse. It is cleared on the edge after it is raised.
- Address arithmetic: adr+k is 32-bit wrap-around; 0xFFFFFFFF+1 = 0.
- rst high mid-operation: immediate return to reset values; a partial write stays partial (no rollback).

Test Plan:
- LW at 0x100, RAM bytes 0x11,0x22,0x33,0x84 -> mem_a_o 0x100..0x103 on consecutive cycles; lsb_en_o pulses 5 edges after accept with lsb_dat_o = 0x84332211; busy_o low next cycle.
- LB vs LBU at 0x20, byte 0xF0 -> LB returns 0xFFFFFFF0 at accept+2; LBU returns 0x000000F0.
- SH adr 0x40, data 0xDEADBEEF -> mem_wr_o high two cycles; writes 0xEF@0x40 then 0xBE@0x41; lsb_en_o at accept+2; nothing written to 0x42.
- SB to 0x30000 with io_buffer_full_i high for 3 cycles -> mem_wr_o stays 0 for those 3 cycles; single write of the byte after release; exactly one done pulse.
- LW accepted, abort_i asserted at accept+2 -> no lsb_en_o; IDLE next edge; a new SW accepted the following cycle completes normally. SW with abort_i mid-write -> all 4 bytes written and done pulse still issued.
- en dropped for 2 cycles in the middle of an SW -> no writes while en is low; the byte in progress is rewritten on resume; 4 byte-writes total, one done pulse.

Source files
------------

// File: rtl/mem_data_ctrl.sv
// mem_data_ctrl: responder for load-store buffer data requests.
// Serialises one load or store onto a byte-wide RAM port, little-endian,
// one byte per cycle, and returns a single-cycle done pulse with the
// (extended) load result. Handles IO-full stalls on IO-region stores,
// branch-misprediction abort of loads and the global en freeze.
module mem_data_ctrl #(
  parameter int ADR_W       = 32,
  parameter int IO_BASE_BIT = 17,
  parameter int OP_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             lsb_en_i,
  input  logic             lsb_rwen_i,
  input  logic [OP_W-1:0]  lsb_op_i,
  input  logic [2:0]       lsb_len_i,
  input  logic [31:0]      lsb_adr_i,
  input  logic [31:0]      lsb_dat_i,
  input  logic             abort_i,
  input  logic             io_buffer_full_i,
  output logic             lsb_en_o,
  output logic [31:0]      lsb_dat_o,
  output logic             busy_o,
  input  logic [7:0]       mem_din_i,
  output logic [7:0]       mem_dout_o,
  output logic [ADR_W-1:0] mem_a_o,
  output logic             mem_wr_o
);

  // Op encodings shared with the load-store buffer
  localparam logic [OP_W-1:0] OP_LB  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LH  = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LW  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_LBU = OP_W'(3);
  localparam logic [OP_W-1:0] OP_LHU = OP_W'(4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t          state;
  logic [OP_W-1:0] op_r;
  logic [2:0]      len_r;
  logic [31:0]     adr_r;
  logic [31:0]     dat_r;
  logic [31:0]     asm_r;
  // cnt: next byte to sample (loads) or byte on the bus (stores)
  logic [2:0]      cnt;
  // iss: next load byte whose address still has to be issued
  logic [2:0]      iss;
  // inflight: address on the bus this cycle belongs to byte iss-1
  logic            inflight;
  // dvld: mem_din_i this cycle carries byte cnt
  logic            dvld;

  logic             stall_now;
  logic             stall_cur;
  logic [2:0]       cnt_nxt;
  logic [7:0]       nxt_byte;
  logic [ADR_W-1:0] iss_adr;
  logic [ADR_W-1:0] nxt_wr_adr;
  logic [31:0]      rd_word;
  logic [31:0]      rd_ext;

  assign busy_o     = (state != IDLE);
  assign stall_now  = (lsb_adr_i[IO_BASE_BIT -: 2] == 2'b11) & io_buffer_full_i;
  assign stall_cur  = (adr_r[IO_BASE_BIT -: 2] == 2'b11) & io_buffer_full_i;
  assign cnt_nxt    = cnt + 3'd1;
  assign nxt_byte   = dat_r[{cnt_nxt[1:0], 3'b000} +: 8];
  assign iss_adr    = ADR_W'(adr_r + {29'd0, iss});
  assign nxt_wr_adr = ADR_W'(adr_r + {29'd0, cnt_nxt});

  // Merge the byte arriving this cycle into the assembly word
  always_comb begin
    rd_word = asm_r;
    rd_word[{cnt[1:0], 3'b000} +: 8] = mem_din_i;
  end

  // Sign- or zero-extend the assembled load according to its op
  always_comb begin
    rd_ext = rd_word;
    case (op_r)
      OP_LB:   rd_ext = {{24{rd_word[7]}}, rd_word[7:0]};
      OP_LH:   rd_ext = {{16{rd_word[15]}}, rd_word[15:0]};
      OP_LBU:  rd_ext = {24'd0, rd_word[7:0]};
      OP_LHU:  rd_ext = {16'd0, rd_word[15:0]};
      OP_LW:   rd_ext = rd_word;
      default: rd_ext = rd_word;
    endcase
  end

  // Request FSM: accept, serialise bytes, stall/abort handling, done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_r       <= '0;
      len_r      <= '0;
      adr_r      <= '0;
      dat_r      <= '0;
      asm_r      <= '0;
      cnt        <= '0;
      iss        <= '0;
      inflight   <= 1'b0;
      dvld       <= 1'b0;
      lsb_en_o   <= 1'b0;
      lsb_dat_o  <= '0;
      mem_dout_o <= '0;
      mem_a_o    <= '0;
      mem_wr_o   <= 1'b0;
    end else if (!en) begin
      // Freeze; a load restarts its pipeline from the oldest unsampled byte
      mem_wr_o <= 1'b0;
      lsb_en_o <= 1'b0;
      if (state == READ) begin
        iss      <= cnt;
        inflight <= 1'b0;
        dvld     <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          lsb_en_o <= 1'b0;
          mem_wr_o <= 1'b0;
          if (lsb_en_i && !abort_i) begin
            op_r    <= lsb_op_i;
            len_r   <= lsb_len_i;
            adr_r   <= lsb_adr_i;
            dat_r   <= lsb_dat_i;
            cnt     <= '0;
            mem_a_o <= ADR_W'(lsb_adr_i);
            if (lsb_rwen_i) begin
              state      <= WRITE;
              mem_dout_o <= lsb_dat_i[7:0];
              mem_wr_o   <= !stall_now;
            end else begin
              state    <= READ;
              asm_r    <= '0;
              iss      <= 3'd1;
              inflight <= 1'b1;
              dvld     <= 1'b0;
            end
          end
        end

        READ: begin
          lsb_en_o <= 1'b0;
          if (abort_i) begin
            state    <= IDLE;
            asm_r    <= '0;
            cnt      <= '0;
            inflight <= 1'b0;
            dvld     <= 1'b0;
          end else begin
            dvld <= inflight;
            if (iss < len_r) begin
              mem_a_o  <= iss_adr;
              iss      <= iss + 3'd1;
              inflight <= 1'b1;
            end else begin
              inflight <= 1'b0;
            end
            if (dvld) begin
              asm_r <= rd_word;
              if (cnt_nxt >= len_r) begin
                lsb_dat_o <= rd_ext;
                lsb_en_o  <= 1'b1;
                state     <= IDLE;
                cnt       <= '0;
                inflight  <= 1'b0;
                dvld      <= 1'b0;
              end else begin
                cnt <= cnt_nxt;
              end
            end
          end
        end

        WRITE: begin
          lsb_en_o <= 1'b0;
          if (mem_wr_o) begin
            if (cnt_nxt >= len_r) begin
              mem_wr_o  <= 1'b0;
              lsb_en_o  <= 1'b1;
              lsb_dat_o <= '0;
              state     <= IDLE;
              cnt       <= '0;
            end else begin
              cnt        <= cnt_nxt;
              mem_a_o    <= nxt_wr_adr;
              mem_dout_o <= nxt_byte;
              mem_wr_o   <= !stall_cur;
            end
          end else begin
            mem_wr_o <= !stall_cur;
          end
        end

        default: begin
          state    <= IDLE;
          lsb_en_o <= 1'b0;
          mem_wr_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_data_ctrl.sv
// tb_mem_data_ctrl: directed bench for mem_data_ctrl with a byte RAM model
// (one-cycle read latency) that logs every write qualified by en.
module tb_mem_data_ctrl;

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LW  = 4'd2;
  localparam logic [3:0] OP_LBU = 4'd3;
  localparam logic [3:0] OP_SB  = 4'd5;
  localparam logic [3:0] OP_SH  = 4'd6;
  localparam logic [3:0] OP_SW  = 4'd7;

  logic        clk;
  logic        rst;
  logic        en;
  logic        lsb_en_i;
  logic        lsb_rwen_i;
  logic [3:0]  lsb_op_i;
  logic [2:0]  lsb_len_i;
  logic [31:0] lsb_adr_i;
  logic [31:0] lsb_dat_i;
  logic        abort_i;
  logic        io_buffer_full_i;
  logic        lsb_en_o;
  logic [31:0] lsb_dat_o;
  logic        busy_o;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  logic [7:0]  ram [logic [31:0]];
  logic [31:0] wr_adr [$];
  logic [7:0]  wr_dat [$];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  mem_data_ctrl #(.ADR_W(32), .IO_BASE_BIT(17), .OP_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .lsb_en_i         (lsb_en_i),
    .lsb_rwen_i       (lsb_rwen_i),
    .lsb_op_i         (lsb_op_i),
    .lsb_len_i        (lsb_len_i),
    .lsb_adr_i        (lsb_adr_i),
    .lsb_dat_i        (lsb_dat_i),
    .abort_i          (abort_i),
    .io_buffer_full_i (io_buffer_full_i),
    .lsb_en_o         (lsb_en_o),
    .lsb_dat_o        (lsb_dat_o),
    .busy_o           (busy_o),
    .mem_din_i        (mem_din),
    .mem_dout_o       (mem_dout),
    .mem_a_o          (mem_a),
    .mem_wr_o         (mem_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read data appears one cycle after its address; writes need en
  always @(posedge clk) begin
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
    if (mem_wr && en) begin
      ram[mem_a] = mem_dout;
      wr_adr.push_back(mem_a);
      wr_dat.push_back(mem_dout);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic rw, input logic [3:0] op, input logic [2:0] len,
                                input logic [31:0] adr, input logic [31:0] dat);
    lsb_rwen_i = rw;
    lsb_op_i   = op;
    lsb_len_i  = len;
    lsb_adr_i  = adr;
    lsb_dat_i  = dat;
    lsb_en_i   = 1'b1;
    tick();
    lsb_en_i   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; lsb_en_i = 1'b0; lsb_rwen_i = 1'b0; lsb_op_i = '0;
    lsb_len_i = '0; lsb_adr_i = '0; lsb_dat_i = '0; abort_i = 1'b0; io_buffer_full_i = 1'b0;
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h84;
    ram[32'h20]  = 8'hF0;

    // Reset values
    tick(); tick();
    check_output("rst_en",   32'(lsb_en_o), 32'd0);
    check_output("rst_dat",  lsb_dat_o, 32'd0);
    check_output("rst_busy", 32'(busy_o), 32'd0);
    check_output("rst_wr",   32'(mem_wr), 32'd0);
    check_output("rst_a",    mem_a, 32'd0);
    check_output("rst_dout", 32'(mem_dout), 32'd0);
    rst = 1'b0;
    tick();

    // LW at 0x100: done 5 edges after accept
    apply_stimulus(1'b0, OP_LW, 3'd4, 32'h100, 32'h0);
    check_output("lw_a0",   mem_a, 32'h100);
    check_output("lw_busy", 32'(busy_o), 32'd1);
    tick(); check_output("lw_a1", mem_a, 32'h101);
    tick(); check_output("lw_a2", mem_a, 32'h102);
    tick(); check_output("lw_a3", mem_a, 32'h103);
    tick(); check_output("lw_early", 32'(lsb_en_o), 32'd0);
    tick();
    check_output("lw_done",  32'(lsb_en_o), 32'd1);
    check_output("lw_dat",   lsb_dat_o, 32'h84332211);
    check_output("lw_idle",  32'(busy_o), 32'd0);
    tick(); check_output("lw_pulse", 32'(lsb_en_o), 32'd0);

    // LB / LBU of 0xF0, and LH sign-extension of 0x8433
    apply_stimulus(1'b0, OP_LB, 3'd1, 32'h20, 32'h0);
    tick(); tick();
    check_output("lb_done", 32'(lsb_en_o), 32'd1);
    check_output("lb_dat",  lsb_dat_o, 32'hFFFFFFF0);
    apply_stimulus(1'b0, OP_LBU, 3'd1, 32'h20, 32'h0);
    tick(); tick();
    check_output("lbu_done", 32'(lsb_en_o), 32'd1);
    check_output("lbu_dat",  lsb_dat_o, 32'h000000F0);
    apply_stimulus(1'b0, OP_LH, 3'd2, 32'h102, 32'h0);
    tick(); tick(); tick();
    check_output("lh_done", 32'(lsb_en_o), 32'd1);
    check_output("lh_dat",  lsb_dat_o, 32'hFFFF8433);
    tick();

    // SH 0xDEADBEEF at 0x40
    wr_adr.delete(); wr_dat.delete();
    apply_stimulus(1'b1, OP_SH, 3'd2, 32'h40, 32'hDEADBEEF);
    check_output("sh_wr0", 32'(mem_wr), 32'd1);
    check_output("sh_a0",  mem_a, 32'h40);
    check_output("sh_d0",  32'(mem_dout), 32'hEF);
    tick();
    check_output("sh_wr1", 32'(mem_wr), 32'd1);
    check_output("sh_a1",  mem_a, 32'h41);
    check_output("sh_d1",  32'(mem_dout), 32'hBE);
    tick();
    check_output("sh_wr2",  32'(mem_wr), 32'd0);
    check_output("sh_done", 32'(lsb_en_o), 32'd1);
    check_output("sh_dat",  lsb_dat_o, 32'd0);
    check_output("sh_cnt",  32'(wr_adr.size()), 32'd2);
    check_output("sh_log1", {wr_adr[1][23:0], wr_dat[1]}, 32'h000041BE);

    // SB to IO region with io_buffer_full_i high for 3 edges
    tick();
    wr_adr.delete(); wr_dat.delete();
    io_buffer_full_i = 1'b1;
    apply_stimulus(1'b1, OP_SB, 3'd1, 32'h30000, 32'h0000005A);
    check_output("io_wr0", 32'(mem_wr), 32'd0);
    tick(); check_output("io_wr1", 32'(mem_wr), 32'd0);
    tick(); check_output("io_wr2", 32'(mem_wr), 32'd0);
    check_output("io_nodone", 32'(lsb_en_o), 32'd0);
    io_buffer_full_i = 1'b0;
    tick();
    check_output("io_wr3", 32'(mem_wr), 32'd1);
    check_output("io_d3",  32'(mem_dout), 32'h5A);
    tick();
    check_output("io_done", 32'(lsb_en_o), 32'd1);
    tick();
    check_output("io_pulse", 32'(lsb_en_o), 32'd0);
    check_output("io_cnt",   32'(wr_adr.size()), 32'd1);
    check_output("io_adr",   wr_adr[0], 32'h30000);

    // LW aborted at accept+2, then SW accepted next cycle
    apply_stimulus(1'b0, OP_LW, 3'd4, 32'h100, 32'h0);
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check_output("ab_busy", 32'(busy_o), 32'd0);
    check_output("ab_a",    mem_a, 32'h101);
    check_output("ab_en",   32'(lsb_en_o), 32'd0);
    wr_adr.delete(); wr_dat.delete();
    apply_stimulus(1'b1, OP_SW, 3'd4, 32'h200, 32'h04030201);
    check_output("ab_sw_en", 32'(lsb_en_o), 32'd0);
    tick(); tick(); tick(); tick();
    check_output("ab_sw_done", 32'(lsb_en_o), 32'd1);
    check_output("ab_sw_cnt",  32'(wr_adr.size()), 32'd4);
    check_output("ab_sw_log3", {wr_adr[3][23:0], wr_dat[3]}, 32'h00020304);

    // SW with abort mid-write still completes
    tick();
    wr_adr.delete(); wr_dat.delete();
    apply_stimulus(1'b1, OP_SW, 3'd4, 32'h300, 32'hA1B2C3D4);
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check_output("swab_busy", 32'(busy_o), 32'd1);
    tick(); tick();
    check_output("swab_done", 32'(lsb_en_o), 32'd1);
    check_output("swab_cnt",  32'(wr_adr.size()), 32'd4);
    check_output("swab_log2", {wr_adr[2][23:0], wr_dat[2]}, 32'h000302B2);

    // SW with en low for 2 edges mid-transfer
    tick();
    wr_adr.delete(); wr_dat.delete();
    apply_stimulus(1'b1, OP_SW, 3'd4, 32'h400, 32'h44332211);
    tick();
    check_output("en_a1", mem_a, 32'h401);
    en = 1'b0;
    tick(); check_output("en_wr_lo1", 32'(mem_wr), 32'd0);
    tick(); check_output("en_wr_lo2", 32'(mem_wr), 32'd0);
    check_output("en_cnt_lo", 32'(wr_adr.size()), 32'd1);
    en = 1'b1;
    tick();
    check_output("en_wr_re", 32'(mem_wr), 32'd1);
    check_output("en_a_re",  mem_a, 32'h401);
    check_output("en_d_re",  32'(mem_dout), 32'h22);
    tick(); tick();
    check_output("en_nodone", 32'(lsb_en_o), 32'd0);
    tick();
    check_output("en_done", 32'(lsb_en_o), 32'd1);
    check_output("en_cnt",  32'(wr_adr.size()), 32'd4);
    check_output("en_log1", {wr_adr[1][23:0], wr_dat[1]}, 32'h00040122);
    check_output("en_log3", {wr_adr[3][23:0], wr_dat[3]}, 32'h00040344);
    tick();
    check_output("en_pulse", 32'(lsb_en_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
